// File: rtl/alu_exec_pkg.sv
// Shared types, opcode constants and the data-processing decoder for alu_exec_unit.
package alu_exec_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_ADC = 3'b100,
        ALU_SBC = 3'b101,
        ALU_EOR = 3'b110,
        ALU_MUL = 3'b111
    } alu_ctl_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ADC = 4'b0101;
    localparam logic [3:0] CMD_SBC = 4'b0110;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [1:0] FLAGW_NONE = 2'b00;
    localparam logic [1:0] FLAGW_NZ   = 2'b10;
    localparam logic [1:0] FLAGW_ALL  = 2'b11;

    typedef struct packed {
        alu_ctl_t   ctl;
        logic       mov;
        logic [1:0] flag_w;
        logic       no_write;
        logic       illegal;
    } dec_t;

    function automatic dec_t decode(input logic alu_op, input logic s, input logic [3:0] cmd,
                                    input logic is_mul, input logic mul_en);
        dec_t d;
        d.ctl      = ALU_ADD;
        d.mov      = 1'b0;
        d.flag_w   = FLAGW_NONE;
        d.no_write = 1'b0;
        d.illegal  = 1'b0;
        if (alu_op) begin
            if (is_mul) begin
                if (mul_en) begin
                    d.ctl    = ALU_MUL;
                    d.flag_w = s ? FLAGW_NZ : FLAGW_NONE;
                end else begin
                    d.illegal = 1'b1;
                end
            end else begin
                case (cmd)
                    CMD_AND: begin d.ctl = ALU_AND; d.flag_w = s ? FLAGW_NZ : FLAGW_NONE;  end
                    CMD_EOR: begin d.ctl = ALU_EOR; d.flag_w = s ? FLAGW_NZ : FLAGW_NONE;  end
                    CMD_ORR: begin d.ctl = ALU_ORR; d.flag_w = s ? FLAGW_NZ : FLAGW_NONE;  end
                    CMD_SUB: begin d.ctl = ALU_SUB; d.flag_w = s ? FLAGW_ALL : FLAGW_NONE; end
                    CMD_ADD: begin d.ctl = ALU_ADD; d.flag_w = s ? FLAGW_ALL : FLAGW_NONE; end
                    CMD_ADC: begin d.ctl = ALU_ADC; d.flag_w = s ? FLAGW_ALL : FLAGW_NONE; end
                    CMD_SBC: begin d.ctl = ALU_SBC; d.flag_w = s ? FLAGW_ALL : FLAGW_NONE; end
                    CMD_TST: begin d.ctl = ALU_AND; d.flag_w = FLAGW_NZ;  d.no_write = 1'b1; end
                    CMD_CMP: begin d.ctl = ALU_SUB; d.flag_w = FLAGW_ALL; d.no_write = 1'b1; end
                    CMD_CMN: begin d.ctl = ALU_ADD; d.flag_w = FLAGW_ALL; d.no_write = 1'b1; end
                    CMD_MOV: begin d.mov = 1'b1;    d.flag_w = s ? FLAGW_NZ : FLAGW_NONE;  end
                    default: d.illegal = 1'b1;
                endcase
            end
            if (d.illegal) begin
                d.flag_w   = FLAGW_NONE;
                d.no_write = 1'b1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between register-read, alu_exec_unit and writeback.
interface alu_exec_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             alu_op;
    logic             s;
    logic [3:0]       cmd;
    logic             is_mul;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       nzcv;
    logic [1:0]       flag_w;
    logic             no_write;
    logic             illegal;

    modport master (
        output flush, in_valid, alu_op, s, cmd, is_mul, src_a, src_b, carry_in, out_ready,
        input  in_ready, out_valid, result, nzcv, flag_w, no_write, illegal
    );

    modport slave (
        input  flush, in_valid, alu_op, s, cmd, is_mul, src_a, src_b, carry_in, out_ready,
        output in_ready, out_valid, result, nzcv, flag_w, no_write, illegal
    );
endinterface

// File: rtl/iter_multiplier.sv
// Shift-add multiplier: one multiplier bit per cycle, low WIDTH bits of the product.
module iter_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic             i_cancel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             r_busy;
    logic [CntW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    // Done is seen during the last step so the caller can capture the final sum on that edge.
    assign o_done     = r_busy && (r_cnt == CntW'(WIDTH - 1));
    assign o_product  = w_acc_next;

    always_ff @(posedge clk) begin
        if (!reset_n || i_cancel) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (o_done) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered ALU execute stage: decode, single-cycle ALU, iterative MUL, valid/ready on both sides.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input logic            clk,
    input logic            reset_n,
    alu_exec_unit_if.slave bus
);
    localparam int unsigned Msb = WIDTH - 1;

    state_t           r_state, w_state_next;
    logic             r_out_valid, w_out_valid_next;
    logic [WIDTH-1:0] r_result, w_result_next;
    logic [3:0]       r_nzcv, w_nzcv_next;
    logic [1:0]       r_flag_w, w_flag_w_next;
    logic             r_no_write, w_no_write_next;
    logic             r_illegal, w_illegal_next;
    logic [1:0]       r_mul_flag_w, w_mul_flag_w_next;
    logic             r_mul_no_write, w_mul_no_write_next;

    dec_t             w_dec;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_is_mul_op;
    logic [WIDTH-1:0] w_op_b;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [3:0]       w_nzcv;
    logic             w_mul_start;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;

    assign w_dec       = decode(bus.alu_op, bus.s, bus.cmd, bus.is_mul, MUL_EN);
    assign w_in_ready  = (r_state == IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_is_mul_op = (w_dec.ctl == ALU_MUL);

    // Subtraction variants invert B; carry-in selects ADD/SUB/ADC/SBC in one adder.
    always_comb begin
        w_op_b = bus.src_b;
        w_cin  = 1'b0;
        unique case (w_dec.ctl)
            ALU_SUB: begin w_op_b = ~bus.src_b; w_cin = 1'b1;         end
            ALU_SBC: begin w_op_b = ~bus.src_b; w_cin = bus.carry_in; end
            ALU_ADC: w_cin = bus.carry_in;
            default: ;
        endcase
    end

    assign w_sum = {1'b0, bus.src_a} + {1'b0, w_op_b} + {{WIDTH{1'b0}}, w_cin};

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        if (w_dec.illegal) begin
            w_res = '0;
        end else if (w_dec.mov) begin
            w_res = bus.src_b;
        end else begin
            unique case (w_dec.ctl)
                ALU_ADD, ALU_SUB, ALU_ADC, ALU_SBC: begin
                    w_res = w_sum[WIDTH-1:0];
                    w_c   = w_sum[WIDTH];
                    w_v   = (bus.src_a[Msb] == w_op_b[Msb]) && (w_sum[Msb] != bus.src_a[Msb]);
                end
                ALU_AND: w_res = bus.src_a & bus.src_b;
                ALU_ORR: w_res = bus.src_a | bus.src_b;
                ALU_EOR: w_res = bus.src_a ^ bus.src_b;
                default: w_res = '0;
            endcase
        end
        w_nzcv = w_dec.illegal ? 4'b0000 : {w_res[Msb], (w_res == '0), w_c, w_v};
    end

    if (MUL_EN) begin : g_mul
        iter_multiplier #(
            .WIDTH(WIDTH)
        ) u_mul (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_start  (w_mul_start),
            .i_cancel (bus.flush),
            .i_a      (bus.src_a),
            .i_b      (bus.src_b),
            .o_done   (w_mul_done),
            .o_product(w_mul_product)
        );
    end else begin : g_no_mul
        assign w_mul_done    = 1'b0;
        assign w_mul_product = '0;
    end

    always_comb begin
        w_state_next        = r_state;
        w_out_valid_next    = r_out_valid;
        w_result_next       = r_result;
        w_nzcv_next         = r_nzcv;
        w_flag_w_next       = r_flag_w;
        w_no_write_next     = r_no_write;
        w_illegal_next      = r_illegal;
        w_mul_flag_w_next   = r_mul_flag_w;
        w_mul_no_write_next = r_mul_no_write;
        w_mul_start         = 1'b0;

        if (r_out_valid && bus.out_ready) begin
            w_out_valid_next = 1'b0;
        end

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_mul_op) begin
                        w_state_next        = BUSY;
                        w_mul_start         = 1'b1;
                        w_mul_flag_w_next   = w_dec.flag_w;
                        w_mul_no_write_next = w_dec.no_write;
                    end else begin
                        w_out_valid_next = 1'b1;
                        w_result_next    = w_res;
                        w_nzcv_next      = w_nzcv;
                        w_flag_w_next    = w_dec.flag_w;
                        w_no_write_next  = w_dec.no_write;
                        w_illegal_next   = w_dec.illegal;
                    end
                end
            end
            BUSY: begin
                if (w_mul_done) begin
                    w_state_next     = IDLE;
                    w_out_valid_next = 1'b1;
                    w_result_next    = w_mul_product;
                    w_nzcv_next      = {w_mul_product[Msb], (w_mul_product == '0), 2'b00};
                    w_flag_w_next    = r_mul_flag_w;
                    w_no_write_next  = r_mul_no_write;
                    w_illegal_next   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n || bus.flush) begin
            r_state        <= IDLE;
            r_out_valid    <= 1'b0;
            r_result       <= '0;
            r_nzcv         <= '0;
            r_flag_w       <= FLAGW_NONE;
            r_no_write     <= 1'b0;
            r_illegal      <= 1'b0;
            r_mul_flag_w   <= FLAGW_NONE;
            r_mul_no_write <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_out_valid    <= w_out_valid_next;
            r_result       <= w_result_next;
            r_nzcv         <= w_nzcv_next;
            r_flag_w       <= w_flag_w_next;
            r_no_write     <= w_no_write_next;
            r_illegal      <= w_illegal_next;
            r_mul_flag_w   <= w_mul_flag_w_next;
            r_mul_no_write <= w_mul_no_write_next;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.nzcv      = r_nzcv;
    assign bus.flag_w    = r_flag_w;
    assign bus.no_write  = r_no_write;
    assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: vector table through a scoreboard plus MUL, back-pressure and cancel cases.
module tb_alu_exec_unit;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  nzcv;
        logic [1:0]  fw;
        logic        nw;
        logic        il;
    } exp_t;

    typedef struct {
        logic        alu_op;
        logic        s;
        logic [3:0]  cmd;
        logic        is_mul;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[16];

    alu_exec_unit_if #(.WIDTH(32)) bus ();
    alu_exec_unit_if #(.WIDTH(32)) bus0 ();

    alu_exec_unit #(.WIDTH(32), .MUL_EN(1'b1)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    alu_exec_unit #(.WIDTH(32), .MUL_EN(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic alu_op, input logic s, input logic [3:0] cmd,
                                input logic is_mul, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic [31:0] r, input logic [3:0] f,
                                input logic [1:0] fw, input logic nw, input logic il);
        vec_t v;
        v.alu_op = alu_op; v.s = s; v.cmd = cmd; v.is_mul = is_mul;
        v.a = a; v.b = b; v.cin = cin;
        v.e.result = r; v.e.nzcv = f; v.e.fw = fw; v.e.nw = nw; v.e.il = il;
        return v;
    endfunction

    // Scoreboard: every completed output transfer is matched against the oldest expectation.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got result %0h, want no output", bus.result);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_result", 64'(bus.result), 64'(mon_e.result));
                chk("sb_nzcv", 64'(bus.nzcv), 64'(mon_e.nzcv));
                chk("sb_flag_w", 64'(bus.flag_w), 64'(mon_e.fw));
                chk("sb_no_write", 64'(bus.no_write), 64'(mon_e.nw));
                chk("sb_illegal", 64'(bus.illegal), 64'(mon_e.il));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input vec_t v, input bit exp_out, output int waited);
        bit ok = 1'b0;
        waited = 0;
        bus.alu_op = v.alu_op; bus.s = v.s; bus.cmd = v.cmd; bus.is_mul = v.is_mul;
        bus.src_a = v.a; bus.src_b = v.b; bus.carry_in = v.cin;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
            end else begin
                waited++;
                @(posedge clk);
                #1;
            end
        end
        if (ok) begin
            if (exp_out) sb.push_back(v.e);
            @(posedge clk);
            #1;
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: got in_ready 0, want 1");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && sb.size() != 0; c++) @(negedge clk);
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Cancel a MUL before BUSY edge 10 using flush (use_reset=0) or reset_n (use_reset=1).
    task automatic cancel_mul(input bit use_reset, input string tag);
        int w;
        int seen;
        issue(mk(1, 1, 4'b0000, 1, 32'h3, 32'h5, 0, 32'hF, 4'b0000, 2'b10, 0, 0), 1'b0, w);
        repeat (9) @(posedge clk);
        #1;
        if (use_reset) reset_n = 1'b0; else bus.flush = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk({tag, "_late_result"}, 64'(seen), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int lat;
        int rdy;

        bus.flush = 0; bus.in_valid = 0; bus.alu_op = 0; bus.s = 0; bus.cmd = 0; bus.is_mul = 0;
        bus.src_a = 0; bus.src_b = 0; bus.carry_in = 0; bus.out_ready = 1;
        bus0.flush = 0; bus0.in_valid = 0; bus0.alu_op = 0; bus0.s = 0; bus0.cmd = 0;
        bus0.is_mul = 0; bus0.src_a = 0; bus0.src_b = 0; bus0.carry_in = 0; bus0.out_ready = 1;

        //            op s  cmd      mul a             b             c  result        nzcv     fw   nw il
        tbl[0]  = mk(1, 1, 4'b0100, 0, 32'h7FFFFFFF, 32'h1,        0, 32'h80000000, 4'b1001, 2'b11, 0, 0);
        tbl[1]  = mk(1, 0, 4'b1010, 0, 32'h5,        32'h5,        0, 32'h0,        4'b0110, 2'b11, 1, 0);
        tbl[2]  = mk(1, 1, 4'b0110, 0, 32'h5,        32'h3,        0, 32'h1,        4'b0010, 2'b11, 0, 0);
        tbl[3]  = mk(0, 1, 4'b1111, 0, 32'h1000,     32'h24,       1, 32'h1024,     4'b0000, 2'b00, 0, 0);
        tbl[4]  = mk(1, 1, 4'b0010, 0, 32'h3,        32'h5,        0, 32'hFFFFFFFE, 4'b1000, 2'b11, 0, 0);
        tbl[5]  = mk(1, 1, 4'b0101, 0, 32'hFFFFFFFF, 32'h0,        1, 32'h0,        4'b0110, 2'b11, 0, 0);
        tbl[6]  = mk(1, 0, 4'b0001, 0, 32'hFF00FF00, 32'h0F0F0F0F, 0, 32'hF00FF00F, 4'b1000, 2'b00, 0, 0);
        tbl[7]  = mk(1, 0, 4'b1000, 0, 32'hF0,       32'h0F,       0, 32'h0,        4'b0100, 2'b10, 1, 0);
        tbl[8]  = mk(1, 0, 4'b1011, 0, 32'h80000000, 32'h80000000, 0, 32'h0,        4'b0111, 2'b11, 1, 0);
        tbl[9]  = mk(1, 1, 4'b1101, 0, 32'h1234,     32'h80000000, 0, 32'h80000000, 4'b1000, 2'b10, 0, 0);
        tbl[10] = mk(1, 1, 4'b1100, 0, 32'h0,        32'h0,        0, 32'h0,        4'b0100, 2'b10, 0, 0);
        tbl[11] = mk(1, 1, 4'b0111, 0, 32'h55,       32'h66,       0, 32'h0,        4'b0000, 2'b00, 1, 1);
        tbl[12] = mk(1, 1, 4'b0010, 0, 32'h80000000, 32'h1,        0, 32'h7FFFFFFF, 4'b0011, 2'b11, 0, 0);
        tbl[13] = mk(1, 1, 4'b0000, 1, 32'h10000,    32'h10000,    0, 32'h0,        4'b0100, 2'b10, 0, 0);
        tbl[14] = mk(1, 0, 4'b0000, 1, 32'h12345,    32'h100,      0, 32'h01234500, 4'b0000, 2'b00, 0, 0);
        tbl[15] = mk(1, 1, 4'b0000, 1, 32'hFFFFFFFF, 32'h3,        0, 32'hFFFFFFFD, 4'b1000, 2'b10, 0, 0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_nzcv", 64'(bus.nzcv), 64'd0);
        chk("rst_flag_w", 64'(bus.flag_w), 64'd0);
        chk("rst_no_write", 64'(bus.no_write), 64'd0);
        chk("rst_illegal", 64'(bus.illegal), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) issue(tbl[i], 1'b1, w);
        drain();

        // Single-cycle latency
        issue(tbl[0], 1'b1, w);
        @(negedge clk);
        chk("add_latency_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        drain();

        // MUL latency and in_ready during BUSY
        issue(tbl[13], 1'b1, w);
        lat = 0;
        rdy = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rdy++;
            @(negedge clk);
            lat++;
        end
        chk("mul_latency", 64'(lat), 64'd32);
        chk("mul_busy_in_ready", 64'(rdy), 64'd0);
        @(posedge clk);
        #1;
        drain();

        // Back-pressure: AND held for 3 cycles, then released with a new request waiting
        bus.out_ready = 1'b0;
        issue(mk(1, 1, 4'b0000, 0, 32'hF0F0, 32'hFF00, 0, 32'hF000, 4'b0000, 2'b10, 0, 0), 1'b1, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_result", 64'(bus.result), 64'hF000);
            chk("bp_flag_w", 64'(bus.flag_w), 64'b10);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        issue(mk(1, 0, 4'b1100, 0, 32'h0F, 32'hF0, 0, 32'hFF, 4'b0000, 2'b00, 0, 0), 1'b1, w);
        chk("bp_back_to_back_wait", 64'(w), 64'd0);
        @(negedge clk);
        chk("bp_second_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        drain();

        // MUL_EN=0: is_mul decodes as illegal
        bus0.alu_op = 1; bus0.s = 1; bus0.cmd = 4'b0100; bus0.is_mul = 1;
        bus0.src_a = 32'h3; bus0.src_b = 32'h4; bus0.in_valid = 1;
        @(negedge clk);
        chk("nomul_in_ready", 64'(bus0.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus0.in_valid = 0;
        @(negedge clk);
        chk("nomul_out_valid", 64'(bus0.out_valid), 64'd1);
        chk("nomul_illegal", 64'(bus0.illegal), 64'd1);
        chk("nomul_no_write", 64'(bus0.no_write), 64'd1);
        chk("nomul_flag_w", 64'(bus0.flag_w), 64'd0);
        chk("nomul_result", 64'(bus0.result), 64'd0);
        @(posedge clk);
        #1;

        cancel_mul(1'b0, "flush");
        cancel_mul(1'b1, "reset");

        // Unit still works after cancellation
        issue(tbl[2], 1'b1, w);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Registered, parametrised successor of the combinational ALU decoder: decodes alu_op/s/cmd and executes the operation on WIDTH-bit operands.
- Adds SBC, MOV/shift pass-through, an iterative multi-cycle MUL, illegal-op detection and valid/ready handshakes on both sides.
- Sits between register-read and writeback in the CPU datapath; flag_w/no_write feed the conditional logic unchanged in meaning.

Parameters:
- WIDTH, 32, operand/result width (>=8).
- MUL_EN, 1, 1 = iterative MUL present; 0 = is_mul decodes as illegal.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous active-low reset
- flush  in  1  synchronous cancel of in-flight MUL and output register
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept
- alu_op  in  1  0 = address add, 1 = data-processing
- s  in  1  set-flags bit
- cmd  in  4  data-processing opcode
- is_mul  in  1  MUL request, overrides cmd
- src_a  in  WIDTH  operand A
- src_b  in  WIDTH  operand B (already shifted externally)
- carry_in  in  1  current C flag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- result  out  WIDTH  result
- nzcv  out  4  {N,Z,C,V} computed flags
- flag_w  out  2  [1] = write N,Z; [0] = write C,V
- no_write  out  1  suppress register writeback
- illegal  out  1  undefined opcode

Behaviour:
- Reset (reset_n=0 at edge): state IDLE, out_valid=0, result=0, nzcv=0, flag_w=00, no_write=0, illegal=0, MUL counter=0. Reset mid-MUL discards the operation. flush has the same effect except in_ready returns 1 next cycle.
- Handshakes:
  - accept = in_valid & in_ready
  - in_ready = (state==IDLE) & (!out_valid | out_ready)
  - output holds stable while out_valid & !out_ready
- Decode (alu_ctl codes in package: ADD 000, SUB 001, AND 010, ORR 011, ADC 100, SBC 101, EOR 110, MUL 111):
  - alu_op=0: ADD, flag_w=00, no_write=0.
  - alu_op=1:
    - AND 0000, EOR 0001, ORR 1100: flag_w = s?10:00
    - SUB 0010, ADD 0100, ADC 0101, SBC 0110: flag_w = s?11:00
    - TST 1000: AND, flag_w=10, no_write=1
    - CMP 1010: SUB, flag_w=11, no_write=1
    - CMN 1011: ADD, flag_w=11, no_write=1
    - MOV/shift 1101: result=src_b, flag_w = s?10:00
    - is_mul=1 with MUL_EN=1: MUL, flag_w = s?10:00
  - Any other cmd, or is_mul with MUL_EN=0: illegal=1, result=0, flag_w=00, no_write=1.
- Arithmetic:
  - SUB = a + ~b + 1; SBC = a + ~b + carry_in; ADC = a + b + carry_in.
  - C = carry out of bit WIDTH-1 (ARM: SUB C=1 means no borrow).
  - V = signed overflow.
  - N = result[WIDTH-1]; Z = (result==0).
  - Logic/MOV/MUL: C=V=0 in nzcv (not written, since flag_w[0]=0).
- Latency:
  - Non-MUL accepted at edge k: out_valid=1 after edge k. Throughput 1/cycle when out_ready=1.
  - MUL: state IDLE→BUSY at accept edge k. One shift-add bit per cycle for WIDTH cycles, edges k+1..k+WIDTH. out_valid=1 after edge k+WIDTH. Result = low WIDTH bits of product. Return to IDLE. in_ready=0 throughout BUSY.
- FSM transitions:
  - IDLE→BUSY on accept & MUL.
  - BUSY→IDLE when counter==WIDTH-1, or on flush/reset.
  - out_valid cleared on out_ready unless a new accept occurs in the same cycle.
- Simultaneous out_ready & accept in IDLE: new result replaces the old one, out_valid stays 1.

Decomposition:
- Package alu_exec_pkg: alu_ctl_t enum, cmd constants (CMD_AND … CMD_MOV), state_t {IDLE, BUSY}, flag_w constants.
- One sub-module, iter_multiplier (parametrised WIDTH): start/done interface, shift-add datapath and counter.
- Decode and single-cycle ALU stay inline.

Test Plan (WIDTH=32, out_ready=1 unless stated):
- ADD s=1, a=0x7FFFFFFF, b=1 → result 0x80000000, nzcv=1001, flag_w=11, out_valid one cycle after accept.
- CMP a=5, b=5 → result 0, nzcv=0110, flag_w=11, no_write=1. SBC a=5, b=3, carry_in=0 → result 1, C=1.
- MUL s=1, a=0x10000, b=0x10000 → result 0, Z=1, flag_w=10. out_valid exactly 32 cycles after accept; in_ready=0 during BUSY.
- Back-pressure: out_ready=0 for 3 cycles after AND → result/flags stable, in_ready=0; releasing out_ready with in_valid=1 → back-to-back accept.
- cmd=0111, alu_op=1 → illegal=1, no_write=1, flag_w=00. MUL_EN=0 with is_mul=1 → illegal=1.
- reset_n=0 or flush=1 at BUSY cycle 10 → out_valid=0 next cycle, in_ready=1, no late result appears.
